// File: rtl/ifetch_prefetch_if.sv
// Fetch-port and flash-port signal bundle for the instruction prefetch buffer.
// slave is the prefetch buffer's view; master is the core/flash environment's view.
`timescale 1ns/1ps
interface ifetch_prefetch_if #(
    parameter int unsigned N = 32
);
    logic         fetch_req;
    logic [N-1:0] fetch_addr;
    logic [N-1:0] instr;
    logic         instr_valid;
    logic         flash_req;
    logic [N-1:0] flash_addr;
    logic         flash_gnt;
    logic         flash_rvalid;
    logic [N-1:0] flash_rdata;

    modport master (
        output fetch_req, fetch_addr, flash_gnt, flash_rvalid, flash_rdata,
        input  instr, instr_valid, flash_req, flash_addr
    );

    modport slave (
        input  fetch_req, fetch_addr, flash_gnt, flash_rvalid, flash_rdata,
        output instr, instr_valid, flash_req, flash_addr
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch queue: streams sequential flash words, hits on the head, flushes on
// redirect. Optional IFB_STATS_EN adds hit_cnt/miss_cnt counters.
`timescale 1ns/1ps
module ifetch_prefetch #(
    parameter int unsigned  N        = 32,
    parameter int unsigned  DEPTH    = 4,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              rstn,
    ifetch_prefetch_if.slave bus
`ifdef IFB_STATS_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  q_addr_q [DEPTH];
    logic [N-1:0]  q_data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  pf_addr_q, pf_addr_d;
    logic [N-1:0]  req_addr_q, req_addr_d;
    logic          stale_q, stale_d;
    logic          flash_req_q, flash_req_d;
    logic [N-1:0]  flash_addr_q, flash_addr_d;

    logic [N-1:0]  aligned, head_addr, head_data, exp_addr;
    logic          not_empty, hit, redirect, push, launch;

    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.fetch_addr[1:0];

    always_comb begin
        aligned   = {bus.fetch_addr[N-1:2], 2'b00};
        head_addr = q_addr_q[rd_ptr_q];
        head_data = q_data_q[rd_ptr_q];
        not_empty = (count_q != '0);

        if (not_empty) begin
            exp_addr = head_addr;
        end else if (state_q != StIdle && !stale_q) begin
            exp_addr = req_addr_q;
        end else begin
            exp_addr = pf_addr_q;
        end

        hit      = bus.fetch_req && not_empty && (head_addr == aligned);
        redirect = bus.fetch_req && (aligned != exp_addr);
        // A word landing in the redirect cycle belongs to the abandoned stream.
        push     = (state_q == StResp) && bus.flash_rvalid && !stale_q && !redirect;

        wr_ptr_d = wr_ptr_q + PW'(push);
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            count_d  = count_q + CW'(push) - CW'(hit);
            rd_ptr_d = rd_ptr_q + PW'(hit);
        end

        state_d    = state_q;
        req_addr_d = req_addr_q;
        pf_addr_d  = pf_addr_q;
        stale_d    = stale_q;
        launch     = 1'b0;

        case (state_q)
            StIdle: launch = 1'b1;
            StReq: begin
                if (bus.flash_gnt) state_d = StResp;
            end
            StResp: begin
                if (bus.flash_rvalid) begin
                    stale_d = 1'b0;
                    launch  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            if (redirect) begin
                state_d    = StReq;
                req_addr_d = aligned;
                pf_addr_d  = aligned + N'(4);
            end else if (count_d < CW'(DEPTH)) begin
                state_d    = StReq;
                req_addr_d = pf_addr_q;
                pf_addr_d  = pf_addr_q + N'(4);
            end else begin
                state_d = StIdle;
            end
        end else if (redirect) begin
            // Outstanding transaction cannot be withdrawn; mark its data for discard.
            pf_addr_d = aligned;
            stale_d   = 1'b1;
        end

        flash_req_d  = (state_d == StReq);
        flash_addr_d = flash_req_d ? req_addr_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            pf_addr_q    <= RESET_PC;
            req_addr_q   <= '0;
            stale_q      <= 1'b0;
            flash_req_q  <= 1'b0;
            flash_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            pf_addr_q    <= pf_addr_d;
            req_addr_q   <= req_addr_d;
            stale_q      <= stale_d;
            flash_req_q  <= flash_req_d;
            flash_addr_q <= flash_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr_q[wr_ptr_q] <= req_addr_q;
            q_data_q[wr_ptr_q] <= bus.flash_rdata;
        end
    end

    assign bus.instr_valid = hit;
    assign bus.instr       = hit ? head_data : '0;
    assign bus.flash_req   = flash_req_q;
    assign bus.flash_addr  = flash_addr_q;

`ifdef IFB_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'(hit);
        miss_cnt_d = miss_cnt_q + 32'(redirect);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch with a behavioural flash responder.
`timescale 1ns/1ps
module tb_ifetch_prefetch;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ifetch_prefetch_if #(.N(32)) ifb ();
`ifdef IFB_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    ifetch_prefetch #(.N(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (ifb)
`ifdef IFB_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;
    int rv_delay   = 1;

    // Flash responder: one rvalid per grant, rv_delay cycles after the grant cycle.
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    always @(posedge clk) begin
        ifb.flash_rvalid <= 1'b0;
        ifb.flash_rdata  <= '0;
        if (!rstn) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (pend_cnt == 0) begin
                    ifb.flash_rvalid <= 1'b1;
                    ifb.flash_rdata  <= pend_addr ^ K;
                    pend             <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
            if (ifb.flash_req && ifb.flash_gnt) begin
                if (rv_delay <= 1) begin
                    ifb.flash_rvalid <= 1'b1;
                    ifb.flash_rdata  <= ifb.flash_addr ^ K;
                end else begin
                    pend      <= 1'b1;
                    pend_cnt  <= rv_delay - 2;
                    pend_addr <= ifb.flash_addr;
                end
            end
        end
    end

    logic [31:0] got_fa_q[$];
    always @(negedge clk) begin
        if (rstn && ifb.flash_req && ifb.flash_gnt) got_fa_q.push_back(ifb.flash_addr);
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        ifb.fetch_req  = 1'b0;
        ifb.fetch_addr = '0;
        ifb.flash_gnt  = 1'b1;
        rv_delay       = 1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        got_fa_q.delete();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        ifb.fetch_req  = 1'b1;
        ifb.fetch_addr = '0;
        ifb.flash_gnt  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ifb.flash_req !== 1'b0) begin
            miscompares++; $display("FAIL reset_flash_req: got %b want 0", ifb.flash_req);
        end
        vectors++;
        if (ifb.flash_addr !== 32'h0) begin
            miscompares++; $display("FAIL reset_flash_addr: got %h want 0", ifb.flash_addr);
        end
        vectors++;
        if (ifb.instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_instr_valid: got %b want 0", ifb.instr_valid);
        end
        vectors++;
        if (ifb.instr !== 32'h0) begin
            miscompares++; $display("FAIL reset_instr: got %h want 0", ifb.instr);
        end
`ifdef IFB_STATS_EN
        vectors++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_stats: got %0d/%0d want 0/0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_boot();
        logic [31:0] exp_q[$];
        logic [31:0] a, e;
        int n, last;
        do_reset();
        a = 32'h0;
        ifb.fetch_req  = 1'b1;
        ifb.fetch_addr = a;
        exp_q.push_back(a ^ K);
        n = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            @(negedge clk);
            if (ifb.instr_valid) begin
                e = exp_q.pop_front();
                vectors++;
                if (ifb.instr !== e) begin
                    miscompares++; $display("FAIL boot_instr: got %h want %h", ifb.instr, e);
                end
                vectors++;
                if (n == 0 && cyc != 3) begin
                    miscompares++; $display("FAIL boot_latency: got cycle %0d want 3", cyc);
                end else if (n > 0 && cyc - last != 2) begin
                    miscompares++;
                    $display("FAIL boot_throughput: got gap %0d want 2", cyc - last);
                end
                last = cyc;
                n++;
            end else begin
                vectors++;
                if (ifb.instr !== 32'h0) begin
                    miscompares++; $display("FAIL boot_instr_idle: got %h want 0", ifb.instr);
                end
            end
            @(posedge clk); #1;
            if (ifb.instr_valid === 1'b0 && exp_q.size() == 0) begin
                a = a + 32'h4;
                ifb.fetch_addr = a;
                exp_q.push_back(a ^ K);
            end
        end
        vectors++;
        if (n != 6) begin
            miscompares++; $display("FAIL boot_timeout: got %0d words want 6", n);
        end
        ifb.fetch_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_fa_q.size() <= i || got_fa_q[i] !== 32'(i * 4)) begin
                miscompares++;
                $display("FAIL boot_flash_order[%0d]: got %h want %h", i,
                         (got_fa_q.size() > i) ? got_fa_q[i] : 32'hxxxxxxxx, 32'(i * 4));
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] exp_fa_q[$];
        do_reset();
        for (int i = 0; i < 4; i++) exp_fa_q.push_back(32'(i * 4));
        repeat (24) @(posedge clk);
        #1;
        vectors++;
        if (got_fa_q.size() != 4) begin
            miscompares++; $display("FAIL fill_grants: got %0d want 4", got_fa_q.size());
        end
        vectors++;
        if (ifb.flash_req !== 1'b0) begin
            miscompares++; $display("FAIL fill_req_idle: got %b want 0", ifb.flash_req);
        end
        ifb.fetch_req  = 1'b1;
        ifb.fetch_addr = 32'h0;
        @(negedge clk);
        vectors++;
        if (ifb.instr_valid !== 1'b1 || ifb.instr !== K) begin
            miscompares++;
            $display("FAIL fill_pop: got v=%b %h want v=1 %h", ifb.instr_valid, ifb.instr, K);
        end
        @(posedge clk); #1;
        ifb.fetch_req = 1'b0;
        exp_fa_q.push_back(32'h10);
        repeat (16) @(posedge clk);
        #1;
        vectors++;
        if (got_fa_q.size() != exp_fa_q.size()) begin
            miscompares++;
            $display("FAIL fill_refill_count: got %0d want %0d", got_fa_q.size(), exp_fa_q.size());
        end
        while (exp_fa_q.size() > 0 && got_fa_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_fa_q.pop_front();
            g = got_fa_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++; $display("FAIL fill_addr: got %h want %h", g, e);
            end
        end
    endtask

    // Runs straight on from test_fill: queue full with 0x4..0x10, FSM idle.
    task automatic test_redirect();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int n;
        ifb.fetch_req  = 1'b1;
        ifb.fetch_addr = 32'h100;
        exp_q.push_back(32'h100 ^ K);
        @(negedge clk);
        vectors++;
        if (ifb.instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL redir_no_valid: got %b want 0", ifb.instr_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (ifb.flash_req !== 1'b1 || ifb.flash_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL redir_flash: got %b %h want 1 100", ifb.flash_req, ifb.flash_addr);
        end
        n = 0;
        for (int cyc = 2; cyc < 24 && n < 2; cyc++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (ifb.instr_valid) begin
                e = exp_q.pop_front();
                vectors++;
                if (ifb.instr !== e) begin
                    miscompares++; $display("FAIL redir_instr: got %h want %h", ifb.instr, e);
                end
                if (n == 0) begin
                    vectors++;
                    if (cyc != 3) begin
                        miscompares++; $display("FAIL redir_latency: got %0d want 3", cyc);
                    end
                end
                n++;
                @(posedge clk); #1;
                ifb.fetch_addr = 32'h104;
                exp_q.push_back(32'h104 ^ K);
                @(negedge clk);
                cyc++;
                if (ifb.instr_valid) begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (ifb.instr !== e) begin
                        miscompares++; $display("FAIL redir_instr: got %h want %h", ifb.instr, e);
                    end
                    n++;
                end
            end
        end
        vectors++;
        if (n != 2) begin
            miscompares++; $display("FAIL redir_timeout: got %0d words want 2", n);
        end
        ifb.fetch_req = 1'b0;
    endtask

    task automatic test_stale();
        logic [31:0] exp_fa_q[$];
        int n;
        do_reset();
        rv_delay       = 3;
        ifb.fetch_req  = 1'b1;
        ifb.fetch_addr = 32'h40;
        exp_fa_q.push_back(32'h40);
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk);
            vectors++;
            if (ifb.instr_valid !== 1'b0) begin
                miscompares++; $display("FAIL stale_early_valid: got 1 want 0 at %0d", cyc);
            end
            @(posedge clk); #1;
        end
        ifb.fetch_addr = 32'h200;
        exp_fa_q.push_back(32'h200);
        n = 0;
        for (int cyc = 2; cyc < 30 && n == 0; cyc++) begin
            @(negedge clk);
            if (ifb.instr_valid) begin
                n++;
                vectors++;
                if (ifb.instr !== (32'h200 ^ K)) begin
                    miscompares++;
                    $display("FAIL stale_instr: got %h want %h", ifb.instr, 32'h200 ^ K);
                end
                vectors++;
                if (cyc != 9) begin
                    miscompares++; $display("FAIL stale_latency: got %0d want 9", cyc);
                end
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (n == 0) begin
            miscompares++; $display("FAIL stale_timeout: got no instr_valid want one");
        end
        ifb.fetch_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (got_fa_q.size() <= i || got_fa_q[i] !== exp_fa_q[i]) begin
                miscompares++;
                $display("FAIL stale_flash_addr[%0d]: got %h want %h", i,
                         (got_fa_q.size() > i) ? got_fa_q[i] : 32'hxxxxxxxx, exp_fa_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int n;
        do_reset();
        ifb.flash_gnt  = 1'b0;
        ifb.fetch_req  = 1'b1;
        ifb.fetch_addr = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC ^ K);
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            vectors++;
            if (ifb.flash_req !== 1'b1 || ifb.flash_addr !== 32'hFFFF_FFFC) begin
                miscompares++;
                $display("FAIL wrap_stall: got %b %h want 1 fffffffc", ifb.flash_req,
                         ifb.flash_addr);
            end
            @(posedge clk); #1;
        end
        ifb.flash_gnt = 1'b1;
        n = 0;
        for (int cyc = 6; cyc < 30 && n < 2; cyc++) begin
            @(negedge clk);
            if (ifb.instr_valid) begin
                e = exp_q.pop_front();
                vectors++;
                if (ifb.instr !== e) begin
                    miscompares++; $display("FAIL wrap_instr: got %h want %h", ifb.instr, e);
                end
                n++;
            end
            @(posedge clk); #1;
            if (n == 1 && exp_q.size() == 0) begin
                ifb.fetch_addr = 32'h0;
                exp_q.push_back(32'h0 ^ K);
            end
        end
        vectors++;
        if (n != 2) begin
            miscompares++; $display("FAIL wrap_timeout: got %0d words want 2", n);
        end
        ifb.fetch_req = 1'b0;
        vectors++;
        if (got_fa_q.size() < 2 || got_fa_q[0] !== 32'hFFFF_FFFC || got_fa_q[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_next_addr: got %h want 00000000",
                     (got_fa_q.size() > 1) ? got_fa_q[1] : 32'hxxxxxxxx);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] exp_q[$];
        logic [31:0] a, e;
        int n;
        bit seen;
        do_reset();
        a = 32'h0;
        ifb.fetch_req  = 1'b1;
        ifb.fetch_addr = a;
        exp_q.push_back(a ^ K);
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
            @(negedge clk);
            if (ifb.instr_valid) begin
                e = exp_q.pop_front();
                vectors++;
                if (ifb.instr !== e) begin
                    miscompares++; $display("FAIL midop_instr: got %h want %h", ifb.instr, e);
                end
                n++;
            end
            @(posedge clk); #1;
            if (exp_q.size() == 0 && n < 3) begin
                a = a + 32'h4;
                ifb.fetch_addr = a;
                exp_q.push_back(a ^ K);
            end
        end
        rv_delay       = 3;
        ifb.fetch_addr = 32'h300;
        @(posedge clk); #1;
        ifb.fetch_req  = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (ifb.flash_req && ifb.flash_gnt && ifb.flash_addr == 32'h300) seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL midop_grant_300: got none want grant at 300");
        end
`ifdef IFB_STATS_EN
        @(negedge clk);
        vectors++;
        if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL stats_count: got %0d/%0d want 3/1", hit_cnt, miss_cnt);
        end
        @(posedge clk); #1;
`endif
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ifb.flash_req !== 1'b0 || ifb.flash_addr !== 32'h0 || ifb.instr_valid !== 1'b0 ||
            ifb.instr !== 32'h0) begin
            miscompares++;
            $display("FAIL midop_reset_outs: got %b %h %b %h want 0 0 0 0", ifb.flash_req,
                     ifb.flash_addr, ifb.instr_valid, ifb.instr);
        end
`ifdef IFB_STATS_EN
        vectors++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            miscompares++;
            $display("FAIL stats_reset: got %0d/%0d want 0/0", hit_cnt, miss_cnt);
        end
`endif
        @(posedge clk); #1;
        rstn = 1'b1;
        rv_delay = 1;
        got_fa_q.delete();
        for (int cyc = 0; cyc < 10 && got_fa_q.size() == 0; cyc++) @(posedge clk);
        #1;
        vectors++;
        if (got_fa_q.size() == 0 || got_fa_q[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL midop_restart_addr: got %h want 00000000",
                     (got_fa_q.size() > 0) ? got_fa_q[0] : 32'hxxxxxxxx);
        end
    endtask

    initial begin
        ifb.fetch_req  = 1'b0;
        ifb.fetch_addr = '0;
        ifb.flash_gnt  = 1'b1;
        test_reset();
        test_boot();
        test_fill();
        test_redirect();
        test_stale();
        test_wrap();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
